// File: rtl/jam_pkg.sv
// Shared definitions for the job-assignment cost-ROM arbiter.
package jam_pkg;

  localparam int unsigned W_IDX       = 3;
  localparam int unsigned W_COST      = 7;
  localparam int unsigned W_SUM       = 10;
  localparam int unsigned NUM_WORKERS = 8;
  // Pointer / engine index width; covers NREQ up to 4.
  localparam int unsigned W_PTR       = 2;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Next index in round-robin order, wrapping at n.
  function automatic logic [W_PTR-1:0] rr_next(input logic [W_PTR-1:0] idx,
                                               input int unsigned n);
    if (32'(idx) == n - 1) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/jam_rr_pick.sv
// Combinational round-robin pick: first valid & mask bit at or after ptr_i
// (mod N) wins; the result is one-hot, or zero when nothing qualifies.
module jam_rr_pick
  import jam_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]     valid_i,
  input  logic [W_PTR-1:0] ptr_i,
  input  logic [N-1:0]     mask_i,
  output logic [N-1:0]     grant_o
);

  logic [N-1:0]   cand;
  logic [2*N-1:0] rot;
  logic           found;

  // Rotate the candidate vector so ptr_i lands at bit 0, then take the first hit.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    cand    = valid_i & mask_i;
    rot     = {cand, cand} >> ptr_i;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found   = 1'b1;
        grant_o = N'(1) << ((32'(ptr_i) + k) % N);
      end
    end
  end

endmodule

// File: rtl/jam_cost_arb.sv
// Round-robin arbiter sharing the cost-ROM read port among NREQ engines.
// Optional port lock is enabled by defining JAM_ARB_LOCK_EN.
module jam_cost_arb
  import jam_pkg::*;
#(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [W_IDX*NREQ-1:0]  req_w,
  input  logic [W_IDX*NREQ-1:0]  req_j,
  input  logic [NREQ-1:0]        req_lock,
  output logic [NREQ-1:0]        req_ready,
  output logic [W_IDX-1:0]       W,
  output logic [W_IDX-1:0]       J,
  input  logic [W_COST-1:0]      Cost,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [W_COST-1:0]      rsp_cost
);

  logic [W_PTR-1:0]  ptr_q, ptr_d;
  logic [W_PTR-1:0]  pick_ptr;
  logic [NREQ-1:0]   pick_mask;
  logic [NREQ-1:0]   grant;
  logic              accept;
  logic [W_PTR-1:0]  acc_idx;
  logic [W_IDX-1:0]  sel_w, sel_j;
  logic              sel_lock;

  logic [W_IDX-1:0]  w_q, j_q;
  logic [W_PTR-1:0]  tag_q;
  logic              inflight_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [W_COST-1:0] rsp_cost_q;

`ifdef JAM_ARB_LOCK_EN
  arb_state_e        state_q, state_d;
  logic [W_PTR-1:0]  owner_q, owner_d;
  logic [4:0]        lock_cnt_q, lock_cnt_d;
  logic              owner_lock;
`else
  logic              lock_unused;
  assign lock_unused = ^req_lock;
`endif

  jam_rr_pick #(.N(NREQ)) u_pick (
    .valid_i (req_valid),
    .ptr_i   (pick_ptr),
    .mask_i  (pick_mask),
    .grant_o (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  // While locked only the owner competes; otherwise everyone from ptr onwards.
  always_comb begin
    pick_mask = '1;
    pick_ptr  = ptr_q;
`ifdef JAM_ARB_LOCK_EN
    if (state_q == LOCK) begin
      pick_mask = NREQ'(1) << owner_q;
      pick_ptr  = owner_q;
    end
`endif
  end

  // Mux the granted engine's request fields.
  always_comb begin
    acc_idx  = '0;
    sel_w    = '0;
    sel_j    = '0;
    sel_lock = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        acc_idx  = W_PTR'(k);
        sel_w    = req_w[W_IDX*k +: W_IDX];
        sel_j    = req_j[W_IDX*k +: W_IDX];
        sel_lock = req_lock[k];
      end
    end
  end

`ifdef JAM_ARB_LOCK_EN
  assign owner_lock = |(req_lock & (NREQ'(1) << owner_q));

  // Arbiter state, pointer, lock owner and grant count registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ARB;
      ptr_q      <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Next-state: enter lock on a locking accept, leave on release or count limit.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      ARB: begin
        if (accept) begin
          ptr_d = rr_next(acc_idx, NREQ);
          if (sel_lock) begin
            state_d    = LOCK;
            owner_d    = acc_idx;
            lock_cnt_d = 5'd1;
          end
        end
      end
      LOCK: begin
        if (accept) begin
          if (!owner_lock || (lock_cnt_q + 5'd1) == 5'(LOCK_MAX)) begin
            state_d    = ARB;
            ptr_d      = rr_next(owner_q, NREQ);
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 5'd1;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end
`else
  // Pure round-robin pointer register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  // Pointer moves past each accepted engine.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = rr_next(acc_idx, NREQ);
  end
`endif

  // ROM address stage: latch the accepted lookup and remember who asked.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      w_q        <= '0;
      j_q        <= '0;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= accept;
      if (accept) begin
        w_q   <= sel_w;
        j_q   <= sel_j;
        tag_q <= acc_idx;
      end
    end
  end

  // Response stage: capture ROM data and strobe the requesting engine.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp_valid_q <= '0;
      rsp_cost_q  <= '0;
    end else if (inflight_q) begin
      rsp_valid_q <= NREQ'(1) << tag_q;
      rsp_cost_q  <= Cost;
    end else begin
      rsp_valid_q <= '0;
    end
  end

  assign W         = w_q;
  assign J         = j_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_cost  = rsp_cost_q;

endmodule

// File: tb/tb_jam_cost_arb.sv
// Self-checking bench for jam_cost_arb with a transaction-level reference model.
module tb_jam_cost_arb;

  localparam int NREQ     = 2;
  localparam int LOCK_MAX = 16;

  logic                CLK = 1'b0;
  logic                RST = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [3*NREQ-1:0]   req_w = '0;
  logic [3*NREQ-1:0]   req_j = '0;
  logic [NREQ-1:0]     req_lock = '0;
  logic [NREQ-1:0]     req_ready;
  logic [2:0]          W, J;
  logic [6:0]          Cost;
  logic [NREQ-1:0]     rsp_valid;
  logic [6:0]          rsp_cost;

  jam_cost_arb #(.NREQ(NREQ), .LOCK_MAX(LOCK_MAX)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_w(req_w), .req_j(req_j), .req_lock(req_lock),
    .req_ready(req_ready), .W(W), .J(J), .Cost(Cost),
    .rsp_valid(rsp_valid), .rsp_cost(rsp_cost)
  );

  always #5 CLK = ~CLK;

  // ROM: cost of (worker, job) = 8*worker + job.
  assign Cost = 7'(8 * int'(W) + int'(J));

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: lookups as a list of pending responses with due cycles.
  typedef struct { int due; int tag; int cost; } rsp_t;
  rsp_t pend[$];
  int   m_ptr, m_owner, m_cnt, m_w, m_j, m_rsp_cost;
  bit   m_locked;
  int   obs_ready;

  function automatic int exp_grant(input logic [NREQ-1:0] v);
    if (m_locked) return v[m_owner] ? m_owner : -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    pend.delete();
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 0;
    m_w = 0; m_j = 0; m_rsp_cost = 0;
  endtask

  // One clock cycle: drive, check outputs, advance the model.
  task automatic step(input logic [NREQ-1:0] v, input logic [3*NREQ-1:0] w,
                      input logic [3*NREQ-1:0] j, input logic [NREQ-1:0] lk);
    int   g;
    rsp_t p;
    @(negedge CLK);
    req_valid = v; req_w = w; req_j = j; req_lock = lk;
    #1;
    g = exp_grant(v);
    obs_ready = int'(req_ready);
    chk("req_ready", int'(req_ready), (g < 0) ? 0 : (1 << g));
    chk("W", int'(W), m_w);
    chk("J", int'(J), m_j);
    if (pend.size() > 0 && pend[0].due == cyc) begin
      p = pend.pop_front();
      m_rsp_cost = p.cost;
      chk("rsp_valid", int'(rsp_valid), 1 << p.tag);
    end else begin
      chk("rsp_valid", int'(rsp_valid), 0);
    end
    chk("rsp_cost", int'(rsp_cost), m_rsp_cost);
    if (g >= 0) begin
      logic [2:0] wi, ji;
      wi = w[3*g +: 3];
      ji = j[3*g +: 3];
      m_w = int'(wi);
      m_j = int'(ji);
      pend.push_back('{cyc + 2, g, 8 * m_w + m_j});
`ifdef JAM_ARB_LOCK_EN
      if (!m_locked) begin
        m_ptr = (g + 1) % NREQ;
        if (lk[g]) begin m_locked = 1; m_owner = g; m_cnt = 1; end
      end else begin
        m_cnt++;
        if (!lk[g] || m_cnt == LOCK_MAX) begin
          m_locked = 0;
          m_ptr = (g + 1) % NREQ;
        end
      end
`else
      m_ptr = (g + 1) % NREQ;
`endif
    end
    @(posedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    req_valid = '1;
    #1;
    model_reset();
    chk("rst_W", int'(W), 0);
    chk("rst_J", int'(J), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_cost", int'(rsp_cost), 0);
    chk("rst_ready_ptr0", int'(req_ready), 1);
    req_valid = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  int seq[$];
  int run;

  initial begin
    model_reset();
    do_reset();

    // Single lookup from engine 0: W=3, J=5 -> cost 29.
    step(2'b01, {3'd0, 3'd3}, {3'd0, 3'd5}, 2'b00);
    #1;
    chk("single_W", int'(W), 3);
    chk("single_J", int'(J), 5);
    step(2'b00, '0, '0, '0);
    #1;
    chk("single_rsp_valid", int'(rsp_valid), 1);
    chk("single_rsp_cost", int'(rsp_cost), 29);
    step(2'b00, '0, '0, '0);
    step(2'b00, '0, '0, '0);

    // Both engines continuously requesting: alternating grants, back-to-back responses.
    do_reset();
    seq.delete();
    for (int i = 0; i < 8; i++) begin
      step(2'b11, 6'($urandom), 6'($urandom), 2'b00);
      seq.push_back(obs_ready);
    end
    for (int i = 0; i < 8; i++) chk("rr_alternate", seq[i], (i % 2 == 0) ? 1 : 2);
    step(2'b00, '0, '0, '0);
    step(2'b00, '0, '0, '0);

    // Engine 1 locks for 7 lookups and releases on the 8th; engine 0 always valid.
    step(2'b01, 6'($urandom), 6'($urandom), 2'b00);
    seq.delete();
    for (int i = 0; i < 9; i++) begin
      step(2'b11, 6'($urandom), 6'($urandom), (i < 7) ? 2'b10 : 2'b00);
      seq.push_back(obs_ready);
    end
    run = 0;
    while (run < seq.size() && seq[run] == 2) run++;
`ifdef JAM_ARB_LOCK_EN
    chk("lock8_run", run, 8);
`else
    chk("lock8_run", run, 1);
`endif
    chk("lock8_next", seq[run], 1);

    // Engine 0 holds lock indefinitely: LOCK_MAX caps the run.
    step(2'b10, 6'($urandom), 6'($urandom), 2'b00);
    seq.delete();
    for (int i = 0; i < LOCK_MAX + 3; i++) begin
      step(2'b11, 6'($urandom), 6'($urandom), 2'b01);
      seq.push_back(obs_ready);
    end
    run = 0;
    while (run < seq.size() && seq[run] == 1) run++;
`ifdef JAM_ARB_LOCK_EN
    chk("lockmax_run", run, LOCK_MAX);
`else
    chk("lockmax_run", run, 1);
`endif
    chk("lockmax_next", seq[run], 2);
    step(2'b00, '0, '0, '0);
    step(2'b00, '0, '0, '0);

    // Reset the cycle after an accept: lookup dropped, ptr back to 0.
    step(2'b01, 6'($urandom), 6'($urandom), 2'b00);
    do_reset();
    for (int i = 0; i < 3; i++) step(2'b00, '0, '0, '0);
    step(2'b11, 6'($urandom), 6'($urandom), 2'b00);
    chk("post_rst_grant", obs_ready, 1);

    // Randomized traffic, including held-off lock owners going idle.
    for (int i = 0; i < 400; i++) begin
      logic [NREQ-1:0] v, lk;
      v  = NREQ'($urandom);
      lk = '0;
      for (int k = 0; k < NREQ; k++) lk[k] = ($urandom_range(0, 3) != 0);
      step(v, 6'($urandom), 6'($urandom), lk);
    end
    step(2'b00, '0, '0, '0);
    step(2'b00, '0, '0, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/jam_cost_arb.md
# jam_cost_arb

Round-robin arbiter that shares the single cost-ROM read port (W/J address out, Cost data in) among NREQ job-assignment search engines. Each engine issues (worker, job) lookups; the arbiter grants one per cycle, drives the ROM address, and returns the 7-bit cost to the granted engine two cycles after acceptance. An optional lock mode lets one engine hold the port for a full 8-lookup permutation evaluation.

## Interface
- NREQ, 2, number of requesting engines (2..4)
- LOCK_MAX, 16, maximum consecutive grants to one engine while locked
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  lookup request per engine
- req_w  in  3*NREQ  worker index, engine i at [3i+2:3i]
- req_j  in  3*NREQ  job index, engine i at [3i+2:3i]
- req_lock  in  NREQ  request port lock after this grant
- req_ready  out  NREQ  one-hot grant, combinational from req_valid and arbiter state
- W  out  3  ROM worker address, registered
- J  out  3  ROM job address, registered
- Cost  in  7  ROM data, valid the cycle after W/J update
- rsp_valid  out  NREQ  one-hot response strobe, registered
- rsp_cost  out  7  returned cost, registered, shared by all engines

## Operation
- Accept: req_valid[i] & req_ready[i]; at most one accept per cycle.
- Round-robin: search starts at pointer ptr; first valid requester at or after ptr (mod NREQ) wins. On accept of i in ARB state, ptr <= (i+1) mod NREQ.
- On accept: W <= req_w[i], J <= req_j[i], tag register <= i, inflight <= 1; otherwise inflight <= 0.
- Response: when inflight, rsp_cost <= Cost, rsp_valid <= one-hot(tag); else rsp_valid <= 0, rsp_cost holds.
- No response backpressure: engines must take rsp_valid/rsp_cost in the strobe cycle.
- States: ARB (round-robin), LOCK (owner only).
- ARB -> LOCK: accept with req_lock[i]=1 (feature enabled); owner <= i, lock_cnt <= 1.
- LOCK: req_ready only for owner; others held off. Each accept increments lock_cnt (5-bit).
- LOCK -> ARB: accept with req_lock[owner]=0, or accept that makes lock_cnt reach LOCK_MAX; ptr <= (owner+1) mod NREQ on exit.
- LOCK with owner req_valid low: stay in LOCK, ROM idle (no timeout other than LOCK_MAX count of grants).
- Reset values: W=0, J=0, rsp_valid=0, rsp_cost=0, req_ready reflects ptr=0 in ARB, state ARB, owner=0, lock_cnt=0, inflight=0.
- Reset mid-operation: in-flight lookup dropped, no rsp_valid after RST release until a new accept.

## Timing
- Accept in cycle t -> W/J valid cycle t+1 -> Cost sampled at end of t+1 -> rsp_valid high cycle t+2.
- Fully pipelined: back-to-back accepts yield back-to-back responses, throughput 1 lookup/cycle.
- req_ready depends combinationally on req_valid; engines must not make req_valid depend on req_ready.
- Simultaneous requests from all engines in ARB: grants rotate, each engine served once per NREQ cycles.

## Configuration
- JAM_ARB_LOCK_EN defined: LOCK state, req_lock and LOCK_MAX behave as above.
- Undefined: req_lock ignored, state stays ARB, owner/lock_cnt logic removed; pure round-robin.

## Structure
- Shared package jam_pkg: widths W_IDX=3, W_COST=7, W_SUM=10, state enum {ARB, LOCK}, NUM_WORKERS=8.
- One sub-module jam_rr_pick: combinational round-robin priority pick (valid vector, pointer, mask) -> one-hot grant.

## Test plan
- Single engine 0, (W=3,J=5), ROM model Cost=8W+J -> W=3,J=5 at t+1, rsp_valid=01, rsp_cost=29 at t+2.
- Both engines valid continuously, ptr=0 -> grants 0,1,0,1; responses alternate one-hot with correct costs, no gaps.
- Lock enabled: engine 1 asserts req_lock for 7 lookups, clears on 8th, engine 0 valid throughout -> eight consecutive grants to 1, then engine 0 granted next.
- Lock enabled, LOCK_MAX=16, engine 0 keeps req_lock=1 -> exactly 16 grants to 0, then engine 1 granted.
- RST asserted cycle after accept -> W=J=0, rsp_valid stays 0 after release, next accept returns ptr=0 priority.
- Macro undefined, req_lock=1 on engine 0, both valid -> strict alternation 0,1,0,1.
